// File: rtl/led_sweeper.sv
// led_sweeper: a moving-head LED display driver.
// A step timer advances a head position through NUM_LEDS outputs in one
// of four patterns (bounce, up-wrap, down-wrap, fill bar). Each LED is
// driven by a 15-step PWM comparator from a per-LED brightness level.
//
// Handshake: there is no valid/ready pair here; step_pulse is a pure
// one-cycle strobe that is high in the same cycle the new pos/dir values
// first appear on the outputs. No acknowledge is expected.
module led_sweeper #(
    parameter int NUM_LEDS      = 16,
    parameter int CLKS_PER_STEP = 25_000_000,
    parameter int TRAIL_LEN     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [3:0]                  speed,
    input  logic [3:0]                  brightness,
    output logic [$clog2(NUM_LEDS)-1:0] pos,
    output logic                        dir,
    output logic                        step_pulse,
    output logic [NUM_LEDS-1:0]         led
);

    localparam int PW = $clog2(NUM_LEDS);

    // Index constants sized to the position register.
    localparam logic [PW-1:0] POS_ZERO = '0;
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] POS_PREV = PW'(NUM_LEDS - 2);

    // Base step period at speed 0, held in the 30-bit timer width.
    localparam logic [29:0] BASE_PERIOD = 30'(CLKS_PER_STEP);

    // PWM counter runs 0..14 so that level 15 means fully on.
    localparam logic [3:0] PWM_LAST = 4'd14;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    mode_e mode_w;
    assign mode_w = mode_e'(mode);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [29:0]         cnt_q, cnt_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                step_pulse_q;
    logic [3:0]          pwm_q, pwm_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    // ------------------------------------------------------------------
    // Step timer
    // ------------------------------------------------------------------
    logic [29:0] period_raw;
    logic [29:0] period;
    logic        at_end;
    logic        fire;

    // Period is recomputed every cycle; a counter already past the new
    // end point fires immediately rather than wrapping the full range.
    always_comb begin
        period_raw = BASE_PERIOD >> speed;
        period     = (period_raw == 30'd0) ? 30'd1 : period_raw;
        at_end     = (cnt_q >= (period - 30'd1));
        fire       = enable & at_end;
        cnt_d      = cnt_q;
        if (enable) begin
            cnt_d = at_end ? 30'd0 : (cnt_q + 30'd1);
        end
    end

    // ------------------------------------------------------------------
    // Position / direction
    // ------------------------------------------------------------------
    // Next head position; mode is only consulted when a step fires, so a
    // mode change never moves the head on its own.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (fire) begin
            case (mode_w)
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = 1'b1;
                            pos_d = POS_PREV;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == POS_ZERO) begin
                            dir_d = 1'b0;
                            pos_d = POS_ONE;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    pos_d = (pos_q == POS_ZERO) ? POS_LAST : (pos_q - POS_ONE);
                end
                default: begin
                    // Up-wrap and fill bar both walk upward and wrap.
                    dir_d = 1'b0;
                    pos_d = (pos_q == POS_LAST) ? POS_ZERO : (pos_q + POS_ONE);
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PWM phase counter
    // ------------------------------------------------------------------
    // Free-running phase, independent of enable.
    always_comb begin
        pwm_d = (pwm_q == PWM_LAST) ? 4'd0 : (pwm_q + 4'd1);
    end

    // ------------------------------------------------------------------
    // Trail positions
    // ------------------------------------------------------------------
    // trail_idx[k] is the LED index k steps behind the head, or -1 when
    // that trail slot is unused or falls off the strip in bounce mode.
    int trail_idx [1:3];

    // Locate the trailing LEDs behind the head, opposite to dir.
    always_comb begin
        int t;
        t = 0;
        for (int k = 1; k <= 3; k++) begin
            trail_idx[k] = -1;
            t = dir_q ? (int'(pos_q) + k) : (int'(pos_q) - k);
            if (k <= TRAIL_LEN) begin
                if (mode_w == MODE_BOUNCE) begin
                    if ((t >= 0) && (t < NUM_LEDS)) begin
                        trail_idx[k] = t;
                    end
                end else begin
                    trail_idx[k] = ((t % NUM_LEDS) + NUM_LEDS) % NUM_LEDS;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-LED level and PWM compare
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
        logic [3:0] lvl;

        // Level for this LED; head wins over any trail slot that aliases it,
        // and nearer trail slots win over farther ones.
        always_comb begin
            lvl = 4'd0;
            if (mode_w == MODE_FILL) begin
                if (g <= int'(pos_q)) begin
                    lvl = brightness;
                end
            end else if (g == int'(pos_q)) begin
                lvl = brightness;
            end else begin
                for (int k = 3; k >= 1; k--) begin
                    if (trail_idx[k] == g) begin
                        lvl = brightness >> k;
                    end
                end
            end
        end

        assign led_d[g] = (pwm_q < lvl);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Step timer and strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 30'd0;
            step_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            step_pulse_q <= fire;
        end
    end

    // Head position and direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= POS_ZERO;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // PWM phase and registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 4'd0;
            led_q <= '0;
        end else begin
            pwm_q <= pwm_d;
            led_q <= led_d;
        end
    end

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign step_pulse = step_pulse_q;
    assign led        = led_q;

endmodule

// File: tb/tb_led_sweeper.sv
// Bench for led_sweeper with NUM_LEDS=8, CLKS_PER_STEP=4, TRAIL_LEN=2.
// Each expected step is queued as {gap, dir, pos}; gap 0 means the
// interval to the previous step is not checked.
module tb_led_sweeper;

    localparam int EW = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] speed = 4'd0;
    logic [3:0] brightness = 4'd15;
    logic [2:0] pos;
    logic       dir;
    logic       step_pulse;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;
    int gap_cnt = 0;
    int on_cnt [8];
    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    led_sweeper #(
        .NUM_LEDS(8),
        .CLKS_PER_STEP(4),
        .TRAIL_LEN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
        .speed(speed),
        .brightness(brightness),
        .pos(pos),
        .dir(dir),
        .step_pulse(step_pulse),
        .led(led)
    );

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] ent(input int gap, input logic d, input int p);
        logic [7:0] g8;
        logic [2:0] p3;
        g8 = gap[7:0];
        p3 = p[2:0];
        return {g8, d, p3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d steps still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Count on-cycles of every LED over one full PWM period; nibble i of
    // expv is the expected count for led[i].
    task automatic check_counts(input string tag, input logic [31:0] expv);
        for (int i = 0; i < 8; i++) on_cnt[i] = 0;
        repeat (15) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) on_cnt[i] += int'(led[i]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (on_cnt[i] != int'(expv[4*i +: 4])) begin
                errors++;
                $display("FAIL %s_led%0d: on %0d of 15 cycles, expected %0d",
                         tag, i, on_cnt[i], int'(expv[4*i +: 4]));
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            gap_cnt = 0;
        end else begin
            gap_cnt = gap_cnt + 1;
            if (step_pulse) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: pos=%0d dir=%0d, expected no step", pos, dir);
                end else begin
                    e = exp_q.pop_front();
                    if (pos !== e[2:0] || dir !== e[3] ||
                        (e[11:4] != 8'd0 && gap_cnt != int'(e[11:4]))) begin
                        errors++;
                        $display("FAIL step: pos=%0d dir=%0d gap=%0d, expected pos=%0d dir=%0d gap=%0d",
                                 pos, dir, gap_cnt, e[2:0], e[3], e[11:4]);
                    end
                end
                gap_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;

        repeat (3) @(negedge clk);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_step", 32'(step_pulse), 32'd0);
        chk("rst_led", 32'(led), 32'd0);

        // Bounce sweep from reset: up to 7, back to 0, then 1.
        tick();
        exp_q.push_back(ent(0, 1'b0, 1));
        for (int p = 2; p <= 7; p++) exp_q.push_back(ent(4, 1'b0, p));
        for (int p = 6; p >= 0; p--) exp_q.push_back(ent(4, 1'b1, p));
        exp_q.push_back(ent(4, 1'b0, 1));
        rst = 1'b0;
        enable = 1'b1;
        wait_drain("bounce", 200);
        enable = 1'b0;           // timer holds at 1

        // Pause: nothing moves, then the held count resumes.
        repeat (20) tick();
        chk("pause_pos", 32'(pos), 32'd1);
        chk("pause_dir", 32'(dir), 32'd0);
        exp_q.push_back(ent(0, 1'b0, 2));
        enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 20);
        enable = 1'b0;           // timer holds at 0
        chk("resume_latency", 32'(n), 32'd3);
        wait_drain("resume", 5);

        // Up-wrap from 2 through 7,0,1.
        mode = 2'b01;
        exp_q.push_back(ent(0, 1'b0, 3));
        for (int p = 4; p <= 7; p++) exp_q.push_back(ent(4, 1'b0, p));
        exp_q.push_back(ent(4, 1'b0, 0));
        exp_q.push_back(ent(4, 1'b0, 1));
        enable = 1'b1;
        wait_drain("up_wrap", 100);

        // Down-wrap from 1: 0,7,6.
        mode = 2'b10;
        exp_q.push_back(ent(4, 1'b1, 0));
        exp_q.push_back(ent(4, 1'b1, 7));
        exp_q.push_back(ent(4, 1'b1, 6));
        wait_drain("down_wrap", 100);
        enable = 1'b0;

        // Asynchronous reset between edges.
        tick();
        tick();
        chk("pre_rst_led6", 32'(led[6]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_pos", 32'(pos), 32'd0);
        chk("async_dir", 32'(dir), 32'd0);
        chk("async_led", 32'(led), 32'd0);
        chk("async_step", 32'(step_pulse), 32'd0);
        mode = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        // LED levels at pos 0: bounce clips the trail, up-wrap wraps it.
        tick();
        tick();
        check_counts("bounce_pos0", 32'h0000_000F);
        mode = 2'b01;
        tick();
        tick();
        check_counts("wrap_pos0", 32'h7300_000F);

        // Step to pos 3 in bounce and check trail levels.
        mode = 2'b00;
        exp_q.push_back(ent(0, 1'b0, 1));
        exp_q.push_back(ent(4, 1'b0, 2));
        exp_q.push_back(ent(4, 1'b0, 3));
        enable = 1'b1;
        wait_drain("to_pos3", 100);
        enable = 1'b0;           // timer holds at 1
        tick();
        tick();
        check_counts("b15_pos3", 32'h0000_F730);
        brightness = 4'd9;
        tick();
        tick();
        check_counts("b9_pos3", 32'h0000_9420);

        // Fill bar at pos 4.
        brightness = 4'd15;
        mode = 2'b11;
        exp_q.push_back(ent(0, 1'b0, 4));
        enable = 1'b1;
        wait_drain("fill_step", 50);
        enable = 1'b0;           // timer holds at 1
        tick();
        tick();
        chk("fill_b15", 32'(led), 32'h1F);
        brightness = 4'd0;
        tick();
        tick();
        chk("fill_b0", 32'(led), 32'h00);
        brightness = 4'd15;

        // Shorten the period while the counter sits at 3: immediate step.
        exp_q.push_back(ent(0, 1'b0, 5));
        exp_q.push_back(ent(2, 1'b0, 6));
        enable = 1'b1;
        tick();
        tick();
        speed = 4'd1;
        wait_drain("speed_change", 50);

        // speed 3 gives a period of 1: a step every cycle.
        speed = 4'd3;
        exp_q.push_back(ent(0, 1'b0, 7));
        exp_q.push_back(ent(1, 1'b0, 0));
        exp_q.push_back(ent(1, 1'b0, 1));
        exp_q.push_back(ent(1, 1'b0, 2));
        exp_q.push_back(ent(1, 1'b0, 3));
        repeat (5) tick();
        enable = 1'b0;
        wait_drain("period_one", 5);
        repeat (3) tick();

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_sweeper.md
LED_SWEEPER -- requirements
Module: led_sweeper

Interface
REQ-001 Parameter NUM_LEDS, default 16: number of LED outputs; legal range 2..64.
REQ-002 Parameter CLKS_PER_STEP, default 25_000_000: clock cycles per position step at speed 0; legal range 1..2^30-1.
REQ-003 Parameter TRAIL_LEN, default 2: number of dimmed trailing LEDs behind the head; legal range 0..3.
REQ-004 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port enable, input, 1: 1 = sweep runs; 0 = pause, with position and step timer frozen.
REQ-007 Port mode, input, 2: 00 bounce, 01 up-wrap, 10 down-wrap, 11 fill bar.
REQ-008 Port speed, input, 4: step period = CLKS_PER_STEP >> speed.
REQ-009 Port brightness, input, 4: head LED duty level, 0..15.
REQ-010 Port pos, output, PW = $clog2(NUM_LEDS): current head index, registered.
REQ-011 Port dir, output, 1: 0 = increasing index, 1 = decreasing index; registered.
REQ-012 Port step_pulse, output, 1: one-cycle strobe, high in the cycle the position advances.
REQ-013 Port led, output, NUM_LEDS: registered PWM drive per LED.

Function
REQ-014 Step timer: a 30-bit counter counts 0..P-1, where P = max(1, CLKS_PER_STEP >> speed) is recomputed every cycle; while enable=1, the counter returns to 0 at P-1 and step_pulse asserts for that cycle.
REQ-015 If speed changes and the counter is already >= the new P-1, the step fires on the next cycle and the counter returns to 0; there is no long wrap-around.
REQ-016 While enable=0: step_pulse=0, and the counter, pos and dir hold; when enable returns to 1, counting resumes from the held value.
REQ-017 Step, mode 00: if dir=0 and pos=NUM_LEDS-1, then dir<=1 and pos<=NUM_LEDS-2; if dir=1 and pos=0, then dir<=0 and pos<=1; otherwise pos moves one index in direction dir. The head never dwells twice at an end.
REQ-018 Step, mode 01: dir<=0; pos increments, and NUM_LEDS-1 wraps to 0.
REQ-019 Step, mode 10: dir<=1; pos decrements, and 0 wraps to NUM_LEDS-1.
REQ-020 Step, mode 11: dir<=0; pos increments, and NUM_LEDS-1 wraps to 0.
REQ-021 A mode change takes effect only at the next step; pos is never reset by a mode change.
REQ-022 PWM: a free-running 4-bit counter c cycles 0..14 (period 15 cycles). An LED at level L is on when c < L, so L=0 is always off and L=15 is always on.
REQ-023 Levels, modes 00/01/10: head at pos has level brightness. The trail LED k steps behind the head (k=1..TRAIL_LEN, opposite to dir) has level brightness >> k. All other LEDs have level 0.
REQ-024 Trail indices wrap modulo NUM_LEDS in modes 01/10. In mode 00, trail indices falling outside 0..NUM_LEDS-1 are not lit.
REQ-025 Levels, mode 11: indices 0..pos have level brightness; all other indices have level 0.
REQ-026 led is registered from the current pos, dir, mode, brightness and c, giving one cycle of latency.

Reset
REQ-027 While rst=1, immediately and independent of clk: pos=0, dir=0, step counter=0, c=0, step_pulse=0, led=0.
REQ-028 On the first rising clk edge after rst falls, normal operation begins with step counting from 0. A reset mid-sweep discards all position state.

Verification
REQ-029 Setup NUM_LEDS=8, CLKS_PER_STEP=4, speed=0, mode=00, enable=1, reset released -> step_pulse on every 4th cycle; pos sequence 0,1,...,7,6,...,0,1; dir toggles at pos 7 and pos 0.
REQ-030 Mode 01 from pos=6 -> pos 7,0,1 on successive steps. Mode 10 from pos=1 -> pos 0,7,6 on successive steps.
REQ-031 CLKS_PER_STEP=4, speed=3 -> P=1, step_pulse high every cycle. Change speed from 0 to 2 while the counter is at 3 -> step fires on the next cycle.
REQ-032 brightness=15, TRAIL_LEN=2, mode 00, pos=0, dir=0 -> led[0] always on; led[7] and led[6] (out of range in bounce, not wrapped) always off. With pos=3, dir=0 -> led[3] always on, led[2] on 7 of 15 cycles, led[1] on 3 of 15 cycles.
REQ-033 Mode 11, brightness=15, pos=4 -> led = 8'b0001_1111; brightness=0 -> led = 0.
REQ-034 enable=0 for 20 cycles mid-count -> pos, dir and counter unchanged and no step_pulse. Assert rst asynchronously between clock edges -> pos=0 and led=0 before the next edge.
